// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-product vending controller with credit, per-item stock and handshaked change return
module vend_ctrl_multi #(
  parameter int NUM_ITEMS  = 4,
  parameter int PRICE_W    = 8,
  parameter int COIN_W     = 4,
  parameter int MAX_CREDIT = 200,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 2,
  localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           coin_valid,
  input  logic [COIN_W-1:0]              coin_val,
  input  logic                           sel_valid,
  input  logic [IW-1:0]                  sel_item,
  input  logic                           cancel,
  input  logic [NUM_ITEMS*PRICE_W-1:0]   price_tbl,
  input  logic                           restock_valid,
  input  logic [IW-1:0]                  restock_item,
  input  logic [STOCK_W-1:0]             restock_qty,
  input  logic                           chg_ready,
  output logic [PRICE_W-1:0]             credit,
  output logic                           vend_valid,
  output logic [IW-1:0]                  vend_item,
  output logic                           chg_valid,
  output logic [1:0]                     chg_coin,
  output logic                           coin_reject,
  output logic                           err_soldout,
  output logic                           err_funds,
  output logic                           busy
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CREDIT = 2'd1;
  localparam logic [1:0] VEND   = 2'd2;
  localparam logic [1:0] CHANGE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PRICE_W-1:0] credit_q, credit_d;
  logic               vend_valid_q, vend_valid_d;
  logic [IW-1:0]      vend_item_q, vend_item_d;
  logic               chg_valid_q, chg_valid_d;
  logic [1:0]         chg_coin_q, chg_coin_d;
  logic               coin_reject_q, coin_reject_d;
  logic               err_soldout_q, err_soldout_d;
  logic               err_funds_q, err_funds_d;
  logic               busy_q, busy_d;
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
  logic [STOCK_W:0]   stock_sum [NUM_ITEMS];
  logic [PRICE_W-1:0] price, chg_amt;
  logic [STOCK_W-1:0] sel_stock;
  logic [PRICE_W:0]   coin_sum;
  logic               dec;

  assign coin_sum = {1'b0, credit_q} + (PRICE_W+1)'(coin_val);
  assign chg_amt  = (credit_q >= PRICE_W'(2)) ? PRICE_W'(2) : PRICE_W'(1);

  // look up price and stock of the selected item; an out-of-range index reads stock 0 and so reports soldout
  always_comb begin
    price     = '0;
    sel_stock = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_item == IW'(i)) begin
        price     = price_tbl[i*PRICE_W +: PRICE_W];
        sel_stock = stock_q[i];
      end
    end
  end

  // FSM: cancel beats selection beats coin while taking credit; busy states reject every coin
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_valid_d  = 1'b0;
    vend_item_d   = '0;
    coin_reject_d = 1'b0;
    err_soldout_d = 1'b0;
    err_funds_d   = 1'b0;
    dec           = 1'b0;
    case (state_q)
      IDLE, CREDIT: begin
        if (cancel && state_q == CREDIT) begin
          state_d       = CHANGE;
          coin_reject_d = coin_valid;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (sel_stock == '0) err_soldout_d = 1'b1;
          else if (credit_q < price) err_funds_d = 1'b1;
          else begin
            credit_d     = credit_q - price;
            dec          = 1'b1;
            state_d      = VEND;
            vend_valid_d = 1'b1;
            vend_item_d  = sel_item;
          end
        end else if (coin_valid && coin_val != '0) begin
          if (coin_sum > (PRICE_W+1)'(MAX_CREDIT)) coin_reject_d = 1'b1;
          else begin
            credit_d = coin_sum[PRICE_W-1:0];
            state_d  = CREDIT;
          end
        end
      end
      VEND: begin
        state_d       = (credit_q != '0) ? CHANGE : IDLE;
        coin_reject_d = coin_valid;
      end
      default: begin
        coin_reject_d = coin_valid;
        if (chg_valid_q && chg_ready) begin
          credit_d = credit_q - chg_amt;
          state_d  = (credit_q == chg_amt) ? IDLE : CHANGE;
        end
      end
    endcase
    chg_valid_d = state_d == CHANGE;
    chg_coin_d  = (state_d == CHANGE) ? ((credit_d >= PRICE_W'(2)) ? 2'b10 : 2'b01) : 2'b00;
    busy_d      = state_d == VEND || state_d == CHANGE;
  end

  // stock update: vend decrement and restock add combine, saturating at all-ones
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_sum[i] = {1'b0, stock_q[i]} - (STOCK_W+1)'(dec && sel_item == IW'(i))
                   + ((restock_valid && restock_item == IW'(i)) ? {1'b0, restock_qty} : '0);
      stock_d[i]   = stock_sum[i][STOCK_W] ? '1 : stock_sum[i][STOCK_W-1:0];
    end
  end

  // state and registered outputs; reset abandons any vend or change in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      vend_valid_q  <= 1'b0;
      vend_item_q   <= '0;
      chg_valid_q   <= 1'b0;
      chg_coin_q    <= 2'b00;
      coin_reject_q <= 1'b0;
      err_soldout_q <= 1'b0;
      err_funds_q   <= 1'b0;
      busy_q        <= 1'b0;
      stock_q       <= '{default: STOCK_W'(INIT_STOCK)};
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_valid_q  <= vend_valid_d;
      vend_item_q   <= vend_item_d;
      chg_valid_q   <= chg_valid_d;
      chg_coin_q    <= chg_coin_d;
      coin_reject_q <= coin_reject_d;
      err_soldout_q <= err_soldout_d;
      err_funds_q   <= err_funds_d;
      busy_q        <= busy_d;
      stock_q       <= stock_d;
    end
  end

  assign credit      = credit_q;
  assign vend_valid  = vend_valid_q;
  assign vend_item   = vend_item_q;
  assign chg_valid   = chg_valid_q;
  assign chg_coin    = chg_coin_q;
  assign coin_reject = coin_reject_q;
  assign err_soldout = err_soldout_q;
  assign err_funds   = err_funds_q;
  assign busy        = busy_q;
endmodule
